// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field widths, exponent constants
// and the state encoding used by the multicycle FPU blocks.
package fpu_pkg;

  localparam int FP_EXP_BIAS = 127;
  localparam int FP_EXP_W    = 8;
  localparam int FP_FRAC_W   = 23;

  // Exponent of a value whose leading one sits in bit 31 (bias + 31).
  localparam logic [FP_EXP_W-1:0] I2F_EXP_INIT = 8'd158;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fpu_mc_state_e;

endpackage

// File: rtl/fpu_round_rne.sv
// Combinational rounding stage for a normalised 24-bit significand.
// Build option FPU_I2F_RNE_EN: defined -> round to nearest, ties to even;
// undefined -> truncate toward zero. inexact is the same in both builds.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac_in,
  input  logic                 guard,
  input  logic                 sticky,
  input  logic [FP_EXP_W-1:0]  exp_in,
  output logic [FP_FRAC_W-1:0] frac_out,
  output logic [FP_EXP_W-1:0]  exp_out,
  output logic                 inexact
);

  logic             round_up;
  logic [FP_FRAC_W:0] frac_sum;

  // Decide the increment, apply it and fold a fraction carry into the exponent.
  always_comb begin
`ifdef FPU_I2F_RNE_EN
    round_up = guard & (sticky | frac_in[0]);
`else
    round_up = 1'b0;
`endif
    frac_sum = {1'b0, frac_in} + {{FP_FRAC_W{1'b0}}, round_up};
    // On carry-out the low bits are already all zero: significand 1.0 x 2^(e+1).
    frac_out = frac_sum[FP_FRAC_W-1:0];
    exp_out  = exp_in + {{(FP_EXP_W-1){1'b0}}, frac_sum[FP_FRAC_W]};
    inexact  = guard | sticky;
  end

endmodule

// File: rtl/fpu_int2float.sv
// 32-bit signed integer to IEEE-754 single converter. Normalises one bit per
// cycle (IDLE -> NORM* -> ROUND -> DONE) behind valid/ready handshakes.
// Rounding mode is selected in fpu_round_rne by FPU_I2F_RNE_EN.
module fpu_int2float
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] A,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] C,
  output logic        inexact,
  output logic        busy
);

  fpu_mc_state_e state_q, state_d;
  logic          sign_q, sign_d;
  logic [31:0]   mag_q, mag_d;
  logic [7:0]    exp_q, exp_d;
  logic [31:0]   c_q, c_d;
  logic          inexact_q, inexact_d;

  logic [31:0]          a_mag;
  logic [FP_FRAC_W-1:0] rnd_frac;
  logic [FP_EXP_W-1:0]  rnd_exp;
  logic                 rnd_inexact;

  // Magnitude of the operand; 0x80000000 wraps to itself, which is the right unsigned value.
  assign a_mag = A[31] ? (~A + 32'd1) : A;

  fpu_round_rne u_round (
    .frac_in  (mag_q[30:8]),
    .guard    (mag_q[7]),
    .sticky   (|mag_q[6:0]),
    .exp_in   (exp_q),
    .frac_out (rnd_frac),
    .exp_out  (rnd_exp),
    .inexact  (rnd_inexact)
  );

  // Next-state and datapath updates; every register holds unless its state acts on it.
  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    c_d       = c_q;
    inexact_d = inexact_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = A[31];
          mag_d  = a_mag;
          exp_d  = I2F_EXP_INIT;
          if (a_mag == 32'd0) begin
            c_d       = 32'd0;
            inexact_d = 1'b0;
            state_d   = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        c_d       = {sign_q, rnd_exp, rnd_frac};
        inexact_d = rnd_inexact;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sign_q    <= 1'b0;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      c_q       <= 32'd0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      c_q       <= c_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign C         = c_q;
  assign inexact   = inexact_q;

endmodule

// File: tb/tb_fpu_int2float.sv
// Bench for fpu_int2float: directed literal cases, stall/reset scenarios and
// randomized operands checked against an arithmetic reference model.
module tb_fpu_int2float;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] C;
  logic        inexact;
  logic        busy;

  fpu_int2float dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .C         (C),
    .inexact   (inexact),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit rand_ready = 1'b0;

  logic [32:0] exp_fifo[$];
  int          lat_fifo[$];
  int          acc_fifo[$];
  bit          lat_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Value of |a| as a plain integer.
  function automatic longint mag_of(input logic [31:0] a);
    longint m;
    m = {32'd0, a};
    if (a[31]) m = 64'sd4294967296 - m;
    return m;
  endfunction

  // Position of the most significant set bit (floor(log2)).
  function automatic int msb_of(input longint m);
    int p;
    p = 0;
    for (int i = 0; i < 32; i++)
      if (m >= (64'sd1 << i)) p = i;
    return p;
  endfunction

  // Reference result {inexact, float bits}: significand = top 24 bits of |a|, rounded.
  function automatic logic [32:0] model(input logic [31:0] a);
    longint m, q, rem;
    int     p, sh;
    logic   inx;
    logic [7:0]  e;
    logic [22:0] fr;
    m = mag_of(a);
    if (m == 0) return 33'd0;
    p   = msb_of(m);
    inx = 1'b0;
    if (p <= 23) begin
      q = m << (23 - p);
    end else begin
      sh  = p - 23;
      q   = m >> sh;
      rem = m - (q << sh);
      inx = (rem != 0);
`ifdef FPU_I2F_RNE_EN
      begin
        longint half;
        half = 64'sd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        if (q == (64'sd1 << 24)) begin
          q = q >> 1;
          p = p + 1;
        end
      end
`endif
    end
    e  = 8'(127 + p);
    fr = 23'(q - (64'sd1 << 23));
    return {inx, a[31], e, fr};
  endfunction

  // Edges after the accept edge until out_valid is visible: one per leading
  // zero plus the move to ROUND and to DONE; zero goes straight to DONE.
  function automatic int model_lat(input logic [31:0] a);
    longint m;
    m = mag_of(a);
    if (m == 0) return 0;
    return 33 - msb_of(m);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure when enabled.
  always @(negedge clk) if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);

  // Scoreboard bookkeeping on accept and output handshakes (pre-edge values).
  always @(posedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        exp_fifo.push_back(model(A));
        lat_fifo.push_back(model_lat(A));
        acc_fifo.push_back(cyc + 1);
      end
      if (out_valid && out_ready && exp_fifo.size() > 0) begin
        void'(exp_fifo.pop_front());
        void'(lat_fifo.pop_front());
        void'(acc_fifo.pop_front());
        lat_done = 1'b0;
      end
    end
  end

  // A reset throws away whatever was in flight.
  always @(negedge rst_n) begin
    exp_fifo.delete();
    lat_fifo.delete();
    acc_fifo.delete();
    lat_done = 1'b0;
  end

  // Compare process: checks outputs on every cycle they are meaningful.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_in_ready", {31'd0, busy}, {31'd0, ~in_ready});
      if (out_valid) begin
        if (exp_fifo.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL spurious_out: out_valid=1 C=%h with no conversion pending (cycle %0d)", C, cyc);
        end else begin
          chk("C", C, exp_fifo[0][31:0]);
          chk("inexact", {31'd0, inexact}, {31'd0, exp_fifo[0][32]});
          chk("in_ready_in_done", {31'd0, in_ready}, 32'd0);
          if (!lat_done) begin
            chk("latency", cyc - acc_fifo[0], lat_fifo[0]);
            lat_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a);
    int k;
    @(negedge clk);
    A = a;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after the accept edge; returns edges until out_valid shows.
  task automatic wait_valid(output int cnt);
    cnt = 0;
    @(negedge clk);
    while (!out_valid && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid_timeout: out_valid=0, expected 1 within 100 cycles");
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy=1, expected 0 within 200 cycles");
    end
  endtask

  task automatic lit(input logic [31:0] a, input logic [31:0] c, input logic inx, input int lat);
    int cnt;
    out_ready = 1'b0;
    send(a);
    wait_valid(cnt);
    chk($sformatf("lit_C_%h", a), C, c);
    chk($sformatf("lit_inexact_%h", a), {31'd0, inexact}, {31'd0, inx});
    chk($sformatf("lit_latency_%h", a), cnt, lat);
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle();
  endtask

  logic [31:0] cases_a[7] = '{32'h80000000, 32'h7FFFFFFF, 32'd1, 32'd0,
                              32'hFFFFFFFF, 32'h00FFFFFF, 32'h01000001};

  initial begin
    int          cnt, sh, sel;
    logic [31:0] saved, a, m24;

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_C", C, 32'd0);
    chk("rst_inexact", {31'd0, inexact}, 32'd0);
    rst_n = 1'b1;

    // Pin the model to hand-computed values.
    chk("model_1", model(32'd1), {1'b0, 32'h3F800000});
    chk("model_m1", model(32'hFFFFFFFF), {1'b0, 32'hBF800000});
    chk("model_min", model(32'h80000000), {1'b0, 32'hCF000000});
    chk("model_5", model(32'd5), {1'b0, 32'h40A00000});
`ifdef FPU_I2F_RNE_EN
    chk("model_01000003", model(32'h01000003), {1'b1, 32'h4B800002});
    chk("model_7fffffff", model(32'h7FFFFFFF), {1'b1, 32'h4F000000});
`else
    chk("model_01000003", model(32'h01000003), {1'b1, 32'h4B800001});
    chk("model_7fffffff", model(32'h7FFFFFFF), {1'b1, 32'h4EFFFFFF});
`endif

    // Directed conversions against literals.
    lit(32'd1,          32'h3F800000, 1'b0, 33);
    lit(32'hFFFFFFFF,   32'hBF800000, 1'b0, 33);
    lit(32'd0,          32'h00000000, 1'b0, 0);
    lit(32'h80000000,   32'hCF000000, 1'b0, 2);
`ifdef FPU_I2F_RNE_EN
    lit(32'h01000003,   32'h4B800002, 1'b1, 9);
    lit(32'h7FFFFFFF,   32'h4F000000, 1'b1, 3);
`else
    lit(32'h01000003,   32'h4B800001, 1'b1, 9);
    lit(32'h7FFFFFFF,   32'h4EFFFFFF, 1'b1, 3);
`endif

    // Stall in DONE, then hand over with a new operand already waiting.
    out_ready = 1'b0;
    send(32'h00001234);
    wait_valid(cnt);
    saved = C;
    repeat (10) begin
      @(negedge clk);
      chk("stall_C", C, saved);
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    A = 32'hFFFF0001;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("handover_in_ready", {31'd0, in_ready}, 32'd1);
    chk("handover_not_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("handover_accepted", {31'd0, busy}, 32'd1);
    wait_idle();

    // Reset while normalising.
    out_ready = 1'b1;
    send(32'd1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    lit(32'd5, 32'h40A00000, 1'b0, 31);

    // Randomized operands with random backpressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = $urandom;
        1: a = $urandom >> $urandom_range(0, 31);
        2: a = -($urandom >> $urandom_range(0, 31));
        3: a = 32'($urandom_range(0, 8)) - 32'd4;
        4: a = cases_a[$urandom_range(0, 6)];
        default: begin
          sh  = $urandom_range(1, 7);
          m24 = 32'h00800000 | ($urandom & 32'h007FFFFF);
          a   = (m24 << sh) | (32'd1 << (sh - 1));
          if ($urandom_range(0, 1) == 1) a = -a;
        end
      endcase
      send(a);
    end
    rand_ready = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
